port_status_controller: RTL and testbench
=========================================

PORT_STATUS_CONTROLLER -- requirements
Module: port_status_controller

Interface
REQ-001 SHALL have parameter CHANNELS, default 1, number of QSFP/HDMI ports handled (legal 1..8).
REQ-002 SHALL have parameter CLOCK_FREQUENCY, default 200_000_000, system_clock frequency in Hz.
REQ-003 SHALL have parameter DEBOUNCE_US, default 1000, presence debounce time; DEBOUNCE_CYCLES = CLOCK_FREQUENCY/1_000_000*DEBOUNCE_US, minimum 1.
REQ-004 SHALL have parameter RESET_HOLD_US, default 10, module reset pulse length; RESET_HOLD_CYCLES derived as for DEBOUNCE_CYCLES, minimum 1.
REQ-005 SHALL have parameter BLINK_HZ, default 2, LED blink rate; BLINK_HALF = CLOCK_FREQUENCY/(2*BLINK_HZ) cycles, minimum 1.
REQ-006 system_clock  in  1  sole clock; all logic on its rising edge.
REQ-007 system_reset  in  1  asynchronous, active-high reset.
REQ-008 pll_locked  in  1  clocking lock status, asynchronous to system_clock.
REQ-009 modprsl  in  CHANNELS  per-port module-present, active-low, asynchronous.
REQ-010 run  in  CHANNELS  per-port stream-running status, system_clock domain.
REQ-011 hpd  out  CHANNELS  debounced module-present, active-high.
REQ-012 module_resetl  out  CHANNELS  per-port module reset, active-low.
REQ-013 channel_enable  out  CHANNELS  per-port release of the HDMI output engine.
REQ-014 led  out  CHANNELS+1  led[0] global lock status; led[i+1] status of port i.

Function
REQ-015 pll_locked and each modprsl bit SHALL pass a 2-flop synchronizer; the synchronized lock is lock_s.
REQ-016 Per port, debounce: counter clears when synchronized ~modprsl equals hpd; otherwise increments; on DEBOUNCE_CYCLES consecutive differing samples hpd takes the new value and the counter clears.
REQ-017 hpd change latency SHALL be exactly 2 + DEBOUNCE_CYCLES cycles from a stable pin change; shorter pulses SHALL not change hpd.
REQ-018 Per port FSM, states ABSENT, RESETTING, ACTIVE.
REQ-019 ABSENT -> RESETTING when hpd=1 and lock_s=1; hold counter loads 0.
REQ-020 RESETTING -> ACTIVE after exactly RESET_HOLD_CYCLES cycles in RESETTING.
REQ-021 RESETTING or ACTIVE -> ABSENT on the next edge whenever hpd=0 or lock_s=0; this SHALL win over a coincident hold-count completion.
REQ-022 module_resetl SHALL be 0 in ABSENT and RESETTING, 1 in ACTIVE; channel_enable SHALL be 1 only in ACTIVE.
REQ-023 One shared free-running blink counter SHALL toggle blink_phase every BLINK_HALF cycles, wrapping to 0.
REQ-024 led[0] SHALL equal lock_s, registered.
REQ-025 led[i+1] SHALL be 0 in ABSENT, blink_phase in RESETTING or in ACTIVE with run[i]=0, 1 in ACTIVE with run[i]=1.
REQ-026 All outputs SHALL be registered; ports SHALL operate independently except the shared lock_s and blink_phase.

Reset
REQ-027 system_reset SHALL asynchronously clear synchronizers, debounce counters, blink counter and blink_phase, force all FSMs to ABSENT, and drive hpd, module_resetl, channel_enable, led to 0.
REQ-028 Reset mid-operation SHALL abort any RESETTING count; after release, each port SHALL re-run debounce from hpd=0.

Verification
(Parameters: CLOCK_FREQUENCY=1_000_000, DEBOUNCE_US=4, RESET_HOLD_US=3, BLINK_HZ=100_000, i.e. BLINK_HALF=5.)
REQ-029 pll_locked=1, modprsl[0] falls -> hpd[0]=1 at edge 6; module_resetl[0]=0 for 3 cycles in RESETTING; then module_resetl[0]=1 and channel_enable[0]=1.
REQ-030 modprsl[0] low for 3 cycles, then high -> hpd[0] stays 0; FSM stays ABSENT.
REQ-031 Port ACTIVE, run[0]=0 -> led[1] toggles every 5 cycles; run[0]=1 -> led[1]=1 from the next edge.
REQ-032 pll_locked falls during RESETTING -> led[0]=0 within 3 cycles; port goes ABSENT; module_resetl[0] stays 0; channel_enable[0] never asserts.
REQ-033 system_reset pulse while ACTIVE -> all outputs 0 immediately, without a clock edge; full debounce and reset sequence repeats after release.
REQ-034 CHANNELS=4, modprsl[2] inserted, then removed -> only hpd[2], module_resetl[2], channel_enable[2], led[3] change; the other ports stay ABSENT.

Source files
------------

// File: rtl/port_status_controller_if.sv
// rtl/port_status_controller_if.sv - pin/status bundle between board logic and the port status controller
interface port_status_controller_if #(
  parameter int CHANNELS = 1
);
  logic                pll_locked;
  logic [CHANNELS-1:0] modprsl;
  logic [CHANNELS-1:0] run;
  logic [CHANNELS-1:0] hpd;
  logic [CHANNELS-1:0] module_resetl;
  logic [CHANNELS-1:0] channel_enable;
  logic [CHANNELS:0]   led;

  modport master (
    output pll_locked, modprsl, run,
    input  hpd, module_resetl, channel_enable, led
  );

  modport slave (
    input  pll_locked, modprsl, run,
    output hpd, module_resetl, channel_enable, led
  );
endinterface

// File: rtl/port_status_controller.sv
// rtl/port_status_controller.sv - per-port presence debounce, module reset sequencing and status LEDs
module port_status_controller #(
  parameter int CHANNELS        = 1,
  parameter int CLOCK_FREQUENCY = 200_000_000,
  parameter int DEBOUNCE_US     = 1000,
  parameter int RESET_HOLD_US   = 10,
  parameter int BLINK_HZ        = 2
) (
  input  logic                    system_clock,
  input  logic                    system_reset,
  port_status_controller_if.slave bus
);
  localparam int DEB_RAW           = CLOCK_FREQUENCY / 1_000_000 * DEBOUNCE_US;
  localparam int DEBOUNCE_CYCLES   = (DEB_RAW < 1) ? 1 : DEB_RAW;
  localparam int HOLD_RAW          = CLOCK_FREQUENCY / 1_000_000 * RESET_HOLD_US;
  localparam int RESET_HOLD_CYCLES = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
  localparam int BLINK_RAW         = CLOCK_FREQUENCY / (2 * BLINK_HZ);
  localparam int BLINK_HALF        = (BLINK_RAW < 1) ? 1 : BLINK_RAW;
  localparam int DW                = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW                = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int BW                = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {ABSENT, RESETTING, ACTIVE} state_t;

  logic                lock_m, lock_s, led0;
  logic [CHANNELS-1:0] pres_m, pres_s;
  logic [BW-1:0]       blink_cnt;
  logic                blink_phase;
  logic [CHANNELS-1:0] hpd_v, mrst_v, en_v, led_v;

  // Presence is synchronized already inverted so the cleared state reads as "absent".
  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      lock_m      <= 1'b0;
      lock_s      <= 1'b0;
      pres_m      <= '0;
      pres_s      <= '0;
      led0        <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      lock_m <= bus.pll_locked;
      lock_s <= lock_m;
      pres_m <= ~bus.modprsl;
      pres_s <= pres_m;
      led0   <= lock_s;
      if (blink_cnt == BW'(BLINK_HALF - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_port
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    logic          hpd_r, mrst_r, en_r, led_r;
    state_t        state;

    always_ff @(posedge system_clock or posedge system_reset) begin
      if (system_reset) begin
        deb_cnt  <= '0;
        hold_cnt <= '0;
        hpd_r    <= 1'b0;
        mrst_r   <= 1'b0;
        en_r     <= 1'b0;
        led_r    <= 1'b0;
        state    <= ABSENT;
      end else begin
        if (pres_s[i] == hpd_r) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          hpd_r   <= pres_s[i];
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end

        // Outputs follow the state being entered so they change on the same edge.
        case (state)
          ABSENT: begin
            mrst_r <= 1'b0;
            en_r   <= 1'b0;
            if (hpd_r && lock_s) begin
              state    <= RESETTING;
              hold_cnt <= '0;
              led_r    <= blink_phase;
            end else begin
              led_r <= 1'b0;
            end
          end
          RESETTING: begin
            if (!hpd_r || !lock_s) begin
              state <= ABSENT;
              led_r <= 1'b0;
            end else if (hold_cnt == HW'(RESET_HOLD_CYCLES - 1)) begin
              state  <= ACTIVE;
              mrst_r <= 1'b1;
              en_r   <= 1'b1;
              led_r  <= bus.run[i] | blink_phase;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
              led_r    <= blink_phase;
            end
          end
          ACTIVE: begin
            if (!hpd_r || !lock_s) begin
              state  <= ABSENT;
              mrst_r <= 1'b0;
              en_r   <= 1'b0;
              led_r  <= 1'b0;
            end else begin
              led_r <= bus.run[i] | blink_phase;
            end
          end
          default: begin
            state  <= ABSENT;
            mrst_r <= 1'b0;
            en_r   <= 1'b0;
            led_r  <= 1'b0;
          end
        endcase
      end
    end

    assign hpd_v[i]  = hpd_r;
    assign mrst_v[i] = mrst_r;
    assign en_v[i]   = en_r;
    assign led_v[i]  = led_r;
  end

  assign bus.hpd            = hpd_v;
  assign bus.module_resetl  = mrst_v;
  assign bus.channel_enable = en_v;
  assign bus.led            = {led_v, led0};
endmodule

// File: tb/tb_port_status_controller.sv
// tb/tb_port_status_controller.sv - randomized and directed bench for port_status_controller
module tb_port_status_controller;
  localparam int CH   = 4;
  localparam int D    = 4;
  localparam int H    = 3;
  localparam int HALF = 5;
  localparam int MAXT = 4096;
  localparam int VW   = 4 * CH + 1;

  logic system_clock = 1'b0;
  logic system_reset = 1'b1;

  port_status_controller_if #(.CHANNELS(CH)) bus ();

  port_status_controller #(
    .CHANNELS(CH), .CLOCK_FREQUENCY(1_000_000), .DEBOUNCE_US(4),
    .RESET_HOLD_US(3), .BLINK_HZ(100_000)
  ) dut (
    .system_clock(system_clock),
    .system_reset(system_reset),
    .bus(bus)
  );

  always #5 system_clock = ~system_clock;

  // Reference model: pin history indexed by edge number since reset release.
  int             t;
  logic           lock_pin [MAXT];
  logic [CH-1:0]  prs_pin  [MAXT];
  logic [CH-1:0]  run_pin  [MAXT];
  logic [CH-1:0]  m_hpd;
  int             m_good [CH];
  logic [CH-1:0]  e_hpd, e_mrst, e_en;
  logic [CH:0]    e_led;
  int             total = 0;
  int             bad   = 0;

  function automatic logic lock_s_after(int k);
    return (k >= 2) ? lock_pin[k-1] : 1'b0;
  endfunction

  function automatic logic pres_after(int k, int i);
    return (k >= 2) ? ~prs_pin[k-1][i] : 1'b0;
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.hpd, bus.module_resetl, bus.channel_enable, bus.led};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_hpd, e_mrst, e_en, e_led};
  endfunction

  task automatic model_clear();
    t = 0; m_hpd = '0; e_hpd = '0; e_mrst = '0; e_en = '0; e_led = '0;
    for (int i = 0; i < CH; i++) m_good[i] = 0;
  endtask

  task automatic step();
    logic          lock_b, diff_all, phase;
    logic [CH-1:0] hpd_b;
    @(posedge system_clock);
    if (t >= MAXT - 2) begin
      $display("FAIL model_history t=%0d limit=%0d", t, MAXT);
      $fatal(1);
    end
    t++;
    lock_pin[t] = bus.pll_locked;
    prs_pin[t]  = bus.modprsl;
    run_pin[t]  = bus.run;
    lock_b = lock_s_after(t - 1);
    hpd_b  = m_hpd;
    phase  = 1'(((t - 1) / HALF) % 2);
    for (int i = 0; i < CH; i++) begin
      // hpd flips only once D consecutive pre-edge samples all disagree with it
      diff_all = (t >= D);
      for (int k = t - D + 1; k <= t; k++)
        if (k >= 1 && pres_after(k - 1, i) == hpd_b[i]) diff_all = 1'b0;
      if (diff_all) m_hpd[i] = ~hpd_b[i];
      m_good[i] = (hpd_b[i] && lock_b) ? ((m_good[i] > H) ? H + 1 : m_good[i] + 1) : 0;
      e_mrst[i]  = (m_good[i] > H);
      e_en[i]    = (m_good[i] > H);
      e_led[i+1] = (m_good[i] == 0) ? 1'b0 : ((m_good[i] > H) ? (run_pin[t][i] | phase) : phase);
    end
    e_hpd    = m_hpd;
    e_led[0] = lock_b;
    #1;
  endtask

  task automatic do_reset();
    system_reset = 1'b1;
    #1;
    model_clear();
    @(negedge system_clock);
    system_reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.pll_locked = 1'b1; bus.modprsl = '1; bus.run = '0;
    do_reset();
    total++;
    if (obs_vec() !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", obs_vec(), {VW{1'b0}});
    end
    for (int n = 0; n < 4; n++) begin
      step(); total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_idle n=%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_insert();
    bus.modprsl[0] = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      step(); total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL insert_model n=%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
      total++;
      if (bus.hpd[0] !== (n >= 6)) begin
        bad++; $display("FAIL insert_hpd n=%0d got=%b want=%b", n, bus.hpd[0], n >= 6);
      end
      total++;
      if ({bus.module_resetl[0], bus.channel_enable[0]} !== {2{n >= 10}}) begin
        bad++; $display("FAIL insert_release n=%0d got=%b%b want=%b", n,
                        bus.module_resetl[0], bus.channel_enable[0], n >= 10);
      end
    end
  endtask

  task automatic test_short_pulse();
    bus.modprsl[1] = 1'b0;
    for (int n = 0; n < 3; n++) step();
    bus.modprsl[1] = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step(); total++;
      if (bus.hpd[1] !== 1'b0 || bus.led[2] !== 1'b0 || obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL short_pulse n=%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_blink_run();
    logic prev, cur;
    int   last, changes;
    bus.run[0] = 1'b0;
    last = -1; changes = 0; prev = bus.led[1];
    for (int n = 0; n < 32; n++) begin
      step(); total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL blink_model n=%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
      cur = bus.led[1];
      if (cur !== prev) begin
        if (last >= 0) begin
          total++;
          if (n - last != HALF) begin
            bad++; $display("FAIL blink_period got=%0d want=%0d", n - last, HALF);
          end
        end
        last = n; changes++;
      end
      prev = cur;
    end
    total++;
    if (changes < 5) begin
      bad++; $display("FAIL blink_toggles got=%0d want>=5", changes);
    end
    bus.run[0] = 1'b1;
    step(); total++;
    if (bus.led[1] !== 1'b1 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL run_led got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_lock_loss();
    bus.pll_locked = 1'b1; bus.modprsl = 4'b1110; bus.run = '0;
    do_reset();
    for (int n = 0; n < 7; n++) step();
    total++;
    if (m_good[0] < 1 || m_good[0] > H || bus.module_resetl[0] !== 1'b0 || bus.led[0] !== 1'b1) begin
      bad++; $display("FAIL lock_setup good=%0d got=%h want=%h", m_good[0], obs_vec(), exp_vec());
    end
    bus.pll_locked = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step(); total++;
      if (obs_vec() !== exp_vec() || bus.module_resetl[0] !== 1'b0 || bus.channel_enable[0] !== 1'b0) begin
        bad++; $display("FAIL lock_loss n=%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
      if (n == 3) begin
        total++;
        if (bus.led[0] !== 1'b0) begin
          bad++; $display("FAIL lock_led got=%b want=0", bus.led[0]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bus.pll_locked = 1'b1; bus.modprsl = 4'b1110; bus.run = 4'b0001;
    do_reset();
    for (int n = 0; n < 12; n++) step();
    total++;
    if (bus.channel_enable[0] !== 1'b1 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL areset_active got=%h want=%h", obs_vec(), exp_vec());
    end
    do_reset();
    total++;
    if (obs_vec() !== '0) begin
      bad++; $display("FAIL areset_clear got=%h want=%h", obs_vec(), {VW{1'b0}});
    end
    for (int n = 1; n <= 12; n++) begin
      step(); total++;
      if (obs_vec() !== exp_vec() || bus.channel_enable[0] !== (n >= 10)) begin
        bad++; $display("FAIL areset_rerun n=%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_isolation();
    bus.pll_locked = 1'b1; bus.modprsl = 4'b1011; bus.run = '0;
    do_reset();
    for (int n = 1; n <= 24; n++) begin
      if (n == 15) bus.modprsl[2] = 1'b1;
      step(); total++;
      if (obs_vec() !== exp_vec() || (bus.hpd & 4'b1011) !== '0 ||
          (bus.channel_enable & 4'b1011) !== '0 || (bus.led & 5'b10110) !== '0) begin
        bad++; $display("FAIL isolation n=%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
      if (n == 14) begin
        total++;
        if (bus.channel_enable[2] !== 1'b1) begin
          bad++; $display("FAIL isolation_active got=%b want=1", bus.channel_enable[2]);
        end
      end
    end
    total++;
    if ({bus.hpd, bus.module_resetl, bus.channel_enable} !== '0) begin
      bad++; $display("FAIL isolation_removed got=%h want=0", obs_vec());
    end
  endtask

  task automatic test_random();
    bus.pll_locked = 1'b1; bus.modprsl = '1; bus.run = '0;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 9) == 0) bus.modprsl[i] = ~bus.modprsl[i];
        if ($urandom_range(0, 11) == 0) bus.run[i] = ~bus.run[i];
      end
      if ($urandom_range(0, 59) == 0) bus.pll_locked = ~bus.pll_locked;
      step(); total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random n=%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_insert();
    test_short_pulse();
    test_blink_run();
    test_lock_loss();
    test_async_reset();
    test_isolation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
